// File: rtl/vermibus_arbiter.sv
// Two-requester round-robin arbiter onto a single device bus, with a per-transfer wait timeout.
// Latency: grant one cycle after valid in IDLE; the completion pulse lands in the same cycle as m_ready.
// Backpressure: a granted requester is stalled by m_ready; the other waits in arbitration.
module vermibus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_wstrobe,
    input  logic [31:0] s0_wdata,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic [31:0] s1_address,
    input  logic [3:0]  s1_wstrobe,
    input  logic [31:0] s1_wdata,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    output logic [31:0] m_address,
    output logic [3:0]  m_wstrobe,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        timeout_error,
    input  logic        error_clear,
    output logic        grant_id
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_grant;
    logic [CW-1:0] wait_cnt;

    logic busy;
    logic sel;
    logic sel_valid;
    logic done;
    logic timeout_hit;
    logic finish;
    logic abort;

    assign busy      = (state == BUSY0) || (state == BUSY1);
    assign sel       = (state == BUSY1);
    assign sel_valid = sel ? s1_valid : s0_valid;

    // The timeout fires once the counter has recorded TIMEOUT_CYCLES unanswered cycles;
    // an m_ready in that same cycle still completes normally.
    assign done        = busy && sel_valid && m_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && sel_valid && !m_ready
                         && (wait_cnt == CW'(TIMEOUT_CYCLES));
    assign finish      = done || timeout_hit;
    assign abort       = busy && !sel_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_nxt = last_grant ? BUSY0 : BUSY1;
                end else if (s0_valid) begin
                    state_nxt = BUSY0;
                end else if (s1_valid) begin
                    state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (abort || finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            wait_cnt      <= '0;
            timeout_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (finish) begin
                last_grant <= sel;
            end
            // Every BUSY state is entered from IDLE, so holding zero there clears it on entry.
            if (!busy) begin
                wait_cnt <= '0;
            end else if (!m_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                timeout_error <= 1'b1;
            end else if (error_clear) begin
                timeout_error <= 1'b0;
            end
        end
    end

    assign m_valid   = busy && sel_valid;
    assign m_address = !busy ? 32'd0 : (sel ? s1_address : s0_address);
    assign m_wstrobe = !busy ? 4'd0  : (sel ? s1_wstrobe : s0_wstrobe);
    assign m_wdata   = !busy ? 32'd0 : (sel ? s1_wdata   : s0_wdata);

    assign s0_ready = (state == BUSY0) && finish;
    assign s1_ready = (state == BUSY1) && finish;
    assign s0_rdata = ((state == BUSY0) && done) ? m_rdata : 32'd0;
    assign s1_rdata = ((state == BUSY1) && done) ? m_rdata : 32'd0;

    assign grant_id = busy ? sel : last_grant;

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Directed bench for vermibus_arbiter: three instances share stimulus (TIMEOUT_CYCLES 4, 0, 3).
module tb_vermibus_arbiter;

    logic        clk;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_address, s1_address;
    logic [3:0]  s0_wstrobe, s1_wstrobe;
    logic [31:0] s0_wdata, s1_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        error_clear;

    logic        o_s0_ready [3];
    logic        o_s1_ready [3];
    logic [31:0] o_s0_rdata [3];
    logic [31:0] o_s1_rdata [3];
    logic        o_m_valid  [3];
    logic [31:0] o_m_address[3];
    logic [3:0]  o_m_wstrobe[3];
    logic [31:0] o_m_wdata  [3];
    logic        o_te       [3];
    logic        o_gid      [3];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vermibus_arbiter #(.TIMEOUT_CYCLES(g == 0 ? 4 : (g == 1 ? 0 : 3))) u_dut (
            .clk           (clk),
            .reset         (reset),
            .s0_valid      (s0_valid),
            .s0_address    (s0_address),
            .s0_wstrobe    (s0_wstrobe),
            .s0_wdata      (s0_wdata),
            .s0_ready      (o_s0_ready[g]),
            .s0_rdata      (o_s0_rdata[g]),
            .s1_valid      (s1_valid),
            .s1_address    (s1_address),
            .s1_wstrobe    (s1_wstrobe),
            .s1_wdata      (s1_wdata),
            .s1_ready      (o_s1_ready[g]),
            .s1_rdata      (o_s1_rdata[g]),
            .m_valid       (o_m_valid[g]),
            .m_address     (o_m_address[g]),
            .m_wstrobe     (o_m_wstrobe[g]),
            .m_wdata       (o_m_wdata[g]),
            .m_ready       (m_ready),
            .m_rdata       (m_rdata),
            .timeout_error (o_te[g]),
            .error_clear   (error_clear),
            .grant_id      (o_gid[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_address = '0; s1_address = '0;
        s0_wstrobe = '0; s1_wstrobe = '0;
        s0_wdata = '0;   s1_wdata = '0;
        m_ready = 1'b0;  m_rdata = '0;
        error_clear = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    logic [1:0] exp_rdy [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    logic       exp_gid [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       seen;

    initial begin
        clear_inputs();
        reset = 1'b0;
        tick();
        check("rst_m_valid",  64'(o_m_valid[0]), 64'd0);
        check("rst_grant_id", 64'(o_gid[0]), 64'd1);
        check("rst_tmo_err",  64'(o_te[0]), 64'd0);
        check("rst_ready",    64'({o_s1_ready[0], o_s0_ready[0]}), 64'd0);
        reset = 1'b1;

        // Single read from s0, device answers after two wait cycles.
        s0_valid = 1'b1; s0_address = 32'h0000_0010;
        #1 check("rd_c0_m_valid", 64'(o_m_valid[0]), 64'd0);
        tick();
        check("rd_c1_m_valid", 64'(o_m_valid[0]), 64'd1);
        check("rd_c1_m_addr",  64'(o_m_address[0]), 64'h10);
        check("rd_c1_grant",   64'(o_gid[0]), 64'd0);
        tick();
        check("rd_c2_ready", 64'(o_s0_ready[0]), 64'd0);
        tick();
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        #1;
        check("rd_c3_s0_ready", 64'(o_s0_ready[0]), 64'd1);
        check("rd_c3_s0_rdata", 64'(o_s0_rdata[0]), 64'h1234_5678);
        check("rd_c3_s1_side",  64'({o_s1_ready[0], o_s1_rdata[0]}), 64'd0);
        tick();
        s0_valid = 1'b0; m_ready = 1'b0;
        #1;
        check("rd_c4_s0_ready", 64'(o_s0_ready[0]), 64'd0);
        check("rd_c4_m_valid",  64'(o_m_valid[0]), 64'd0);
        check("rd_c4_grant",    64'(o_gid[0]), 64'd0);

        // Both requesters held valid with an always-ready device: strict alternation.
        apply_reset();
        s0_valid = 1'b1; s1_valid = 1'b1;
        s0_address = 32'h100; s1_address = 32'h200;
        m_ready = 1'b1; m_rdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("rr_c%0d_ready", c), 64'({o_s1_ready[0], o_s0_ready[0]}), 64'(exp_rdy[c]));
            check($sformatf("rr_c%0d_grant", c), 64'(o_gid[0]), 64'(exp_gid[c]));
            check($sformatf("rr_c%0d_rdata", c), {o_s1_rdata[0], o_s0_rdata[0]},
                  {(exp_rdy[c][1] ? 32'hA5A5_A5A5 : 32'd0), (exp_rdy[c][0] ? 32'hA5A5_A5A5 : 32'd0)});
            tick();
        end
        clear_inputs();

        // s1 write times out after four unanswered BUSY1 cycles.
        apply_reset();
        s1_valid = 1'b1; s1_address = 32'h40; s1_wstrobe = 4'hF; s1_wdata = 32'hDEAD_BEEF;
        m_rdata = 32'h5555_5555;
        tick();
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("to_c%0d_s1_ready", c), 64'(o_s1_ready[0]), 64'(c == 5));
            if (c == 1) begin
                check("to_m_fields", {o_m_address[0], o_m_wstrobe[0], o_m_wdata[0][27:0]},
                      {32'h40, 4'hF, 28'hEAD_BEEF});
            end
            if (c == 5) begin
                check("to_s1_rdata", 64'(o_s1_rdata[0]), 64'd0);
            end
            tick();
        end
        s1_valid = 1'b0;
        #1;
        check("to_err_set",   64'(o_te[0]), 64'd1);
        check("to_idle_mval", 64'(o_m_valid[0]), 64'd0);
        repeat (3) tick();
        check("to_err_sticky", 64'(o_te[0]), 64'd1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        #1 check("to_err_cleared", 64'(o_te[0]), 64'd0);

        // Clear and new timeout in the same cycle: set wins.
        apply_reset();
        s0_valid = 1'b1;
        repeat (5) tick();
        error_clear = 1'b1;
        #1 check("clr_vs_set_ready", 64'(o_s0_ready[0]), 64'd1);
        tick();
        error_clear = 1'b0; s0_valid = 1'b0;
        #1 check("clr_vs_set_err", 64'(o_te[0]), 64'd1);

        // Timeout disabled: 1000 cycles with no device response.
        apply_reset();
        s0_valid = 1'b1;
        seen = 1'b0;
        repeat (1000) begin
            tick();
            seen = seen | o_s0_ready[1] | o_s1_ready[1];
        end
        check("t0_no_ready", 64'(seen), 64'd0);
        check("t0_no_err",   64'(o_te[1]), 64'd0);
        check("t0_m_valid",  64'(o_m_valid[1]), 64'd1);
        // Requester drops valid mid-transfer: abandoned without a ready pulse.
        s0_valid = 1'b0;
        #1 check("drop_m_valid", 64'(o_m_valid[1]), 64'd0);
        tick();
        check("drop_idle", 64'({o_m_valid[1], o_s0_ready[1], o_gid[1]}), 64'b001);

        // Reset during BUSY0, then a pending tie goes to s0.
        apply_reset();
        s0_valid = 1'b1; s0_address = 32'h80; s1_address = 32'h90;
        tick();
        tick();
        check("mid_busy", 64'(o_m_valid[0]), 64'd1);
        s1_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_mval",  64'(o_m_valid[0]), 64'd0);
        check("mid_rst_grant", 64'(o_gid[0]), 64'd1);
        check("mid_rst_outs",  64'({o_s0_ready[0], o_m_address[0]}), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_grant", 64'(o_gid[0]), 64'd0);
        check("post_rst_addr",  64'(o_m_address[0]), 64'h80);
        clear_inputs();

        // m_ready arrives exactly in the timeout cycle (TIMEOUT_CYCLES=3).
        apply_reset();
        s0_valid = 1'b1; m_rdata = 32'hCAFE_0001;
        repeat (4) tick();
        m_ready = 1'b1;
        #1;
        check("tie_s0_ready", 64'(o_s0_ready[2]), 64'd1);
        check("tie_s0_rdata", 64'(o_s0_rdata[2]), 64'hCAFE_0001);
        tick();
        s0_valid = 1'b0; m_ready = 1'b0;
        #1 check("tie_no_err", 64'(o_te[2]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vermibus_arbiter.md
VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, max cycles a granted transfer waits for m_ready; 0 disables timeout.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 s0_valid, s1_valid  in  1 each  requester 0/1 transfer request.
REQ-005 s0_address, s1_address  in  32 each  requester byte address.
REQ-006 s0_wstrobe, s1_wstrobe  in  4 each  byte write strobes; 0 means read.
REQ-007 s0_wdata, s1_wdata  in  32 each  write data.
REQ-008 s0_ready, s1_ready  out  1 each  one-cycle transfer-complete pulse to requester.
REQ-009 s0_rdata, s1_rdata  out  32 each  read data, meaningful only with the matching ready.
REQ-010 m_valid, m_address[32], m_wstrobe[4], m_wdata[32]  out  request to the shared device bus.
REQ-011 m_ready  in  1, m_rdata  in  32  response from the shared device bus.
REQ-012 timeout_error  out  1  sticky flag, set on any timed-out transfer.
REQ-013 error_clear  in  1  synchronous clear of timeout_error.
REQ-014 grant_id  out  1  index of the current or last granted requester.

Function
REQ-015 FSM states: IDLE, BUSY0, BUSY1; state is registered.
REQ-016 IDLE, only s0_valid: next state BUSY0; only s1_valid: BUSY1; neither: stay IDLE.
REQ-017 IDLE, both valid: grant the requester not equal to last_grant (round-robin); after reset last_grant=1, so s0 wins first tie.
REQ-018 Grant latency: exactly one cycle from valid seen in IDLE to m_valid asserted.
REQ-019 BUSYn: m_valid = sn_valid; m_address/m_wstrobe/m_wdata = requester n fields (combinational mux).
REQ-020 IDLE: m_valid=0; m_address, m_wstrobe, m_wdata = 0.
REQ-021 BUSYn with m_ready=1: sn_ready=1 for that cycle, sn_rdata=m_rdata, last_grant<=n, next state IDLE.
REQ-022 Non-granted requester: ready=0 and rdata=0 at all times.
REQ-023 Requesters hold valid and fields stable until ready; the arbiter does not register request fields.
REQ-024 BUSYn with sn_valid dropped before m_ready (protocol violation): return to IDLE next cycle, no ready pulse, last_grant unchanged.
REQ-025 Wait counter, width clog2(TIMEOUT_CYCLES+1): cleared on entry to BUSYn, increments each BUSYn cycle with m_ready=0.
REQ-026 Counter reaching TIMEOUT_CYCLES (nonzero) with m_ready=0: sn_ready=1, sn_rdata=0, timeout_error<=1, last_grant<=n, next state IDLE.
REQ-027 m_ready and timeout in same cycle: normal completion wins, timeout_error not set.
REQ-028 error_clear and a new timeout in same cycle: timeout_error ends at 1 (set wins).
REQ-029 Back-to-back: requester re-asserting valid the cycle after its ready re-enters arbitration in IDLE; a waiting other requester wins that cycle.
REQ-030 m_ready seen in IDLE is ignored.
REQ-031 grant_id = n in BUSYn; in IDLE = last_grant.

Reset
REQ-032 reset low, asynchronously: state=IDLE, last_grant=1, counter=0, timeout_error=0.
REQ-033 During reset all outputs are 0 except grant_id=1.
REQ-034 Reset mid-transfer aborts it: no ready pulse issued; requester must re-issue.

Verification
REQ-035 s0 read 0x0000_0010, device ready after 2 wait cycles with m_rdata=0x1234_5678 -> m_valid at cycle 1, s0_ready pulse at cycle 3 with s0_rdata=0x1234_5678, s1_ready=0.
REQ-036 s0 and s1 held valid, device always ready -> grants alternate 0,1,0,1 with one IDLE cycle between; each ready one cycle.
REQ-037 TIMEOUT_CYCLES=4, s1 write, m_ready held 0 -> s1_ready pulse with s1_rdata=0 after 4 BUSY1 cycles, timeout_error=1 until error_clear pulse.
REQ-038 TIMEOUT_CYCLES=0, m_ready held 0 for 1000 cycles -> no ready, timeout_error stays 0.
REQ-039 reset low during BUSY0 with m_ready=0 -> outputs 0 immediately, grant_id=1; after release, pending s0/s1 tie grants s0.
REQ-040 m_ready and timeout coincide at TIMEOUT_CYCLES=3 -> s0_rdata=m_rdata, timeout_error=0.
